// File: rtl/simon_word_if.sv
// simon_word_if -- word-serial front/back end for the SIMON 64/128 core.
// Packs 32-bit words from a valid/ready stream into a 128-bit key or a
// 64-bit block, drives the core's newKey/loadKey and newData/loadData
// handshakes, captures the result on doneData, and streams it back out.
// Optional build macro: SIMON_WORD_IF_ZEROISE_EN clears KEY, blockIN and
// the result register once each has been handed off.
module simon_word_if #(
  parameter int unsigned N = 32,
  parameter int unsigned M = 4
) (
  input  logic             clk,
  input  logic             nR,
  // input word stream
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_word,
  input  logic             in_kind,
  input  logic             in_dec,
  // result word stream
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     out_word,
  output logic             key_ok,
  // cipher core side
  output logic             newKey,
  output logic             newData,
  output logic             enc_dec,
  output logic             readData,
  output logic [M*N-1:0]   KEY,
  output logic [2*N-1:0]   blockIN,
  input  logic             loadKey,
  input  logic             loadData,
  input  logic             doneKey,
  input  logic             doneData,
  input  logic [2*N-1:0]   outData
);

  localparam int unsigned KW = (M > 1) ? $clog2(M) : 1;
  localparam logic [KW-1:0] KLAST = KW'(M - 1);

  typedef enum logic [3:0] {
    IDLE,
    KCOL,
    KREQ,
    KEXP,
    DCOL,
    DREQ,
    DWAIT,
    OUT0,
    OUT1
  } state_t;

  state_t          state_q, state_d;
  logic [KW-1:0]   kcnt_q;
  logic [M*N-1:0]  key_q;
  logic [2*N-1:0]  blk_q;
  logic [2*N-1:0]  res_q;
  logic            key_ok_q;
  logic            enc_dec_q;
  logic            rd_q;
  logic            acc;

  assign acc = in_valid & in_ready;

  // State register, synchronous active-high reset
  always_ff @(posedge clk) begin
    if (nR) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (acc) begin
          if (in_kind) begin
            state_d = (kcnt_q == KLAST) ? KREQ : KCOL;
          end else begin
            state_d = DCOL;
          end
        end
      end
      KCOL:    if (acc && (kcnt_q == KLAST)) state_d = KREQ;
      KREQ:    if (loadKey)                  state_d = KEXP;
      KEXP:    if (doneKey)                  state_d = IDLE;
      DCOL:    if (acc)                      state_d = DREQ;
      DREQ:    if (loadData)                 state_d = DWAIT;
      DWAIT:   if (doneData)                 state_d = OUT0;
      OUT0:    if (out_ready)                state_d = OUT1;
      OUT1:    if (out_ready)                state_d = IDLE;
      default:                               state_d = IDLE;
    endcase
  end

  // Decoded outputs; in_ready is forced low while reset is asserted so no
  // word can be accepted in the reset cycle itself
  always_comb begin
    in_ready  = 1'b0;
    newKey    = 1'b0;
    newData   = 1'b0;
    out_valid = 1'b0;
    out_word  = '0;
    case (state_q)
      // key words need nothing; data words need an expanded key
      IDLE: in_ready = in_kind | key_ok_q;
      // a partial collection only takes words of its own kind
      KCOL: in_ready = in_kind;
      DCOL: in_ready = ~in_kind;
      KREQ: newKey   = 1'b1;
      DREQ: newData  = 1'b1;
      OUT0: begin
        out_valid = 1'b1;
        out_word  = res_q[2*N-1:N];
      end
      OUT1: begin
        out_valid = 1'b1;
        out_word  = res_q[N-1:0];
      end
      default: ;
    endcase
    if (nR) in_ready = 1'b0;
  end

  // Datapath: word packing, key-valid flag, result capture, readData pulse
  always_ff @(posedge clk) begin
    if (nR) begin
      kcnt_q    <= '0;
      key_q     <= '0;
      blk_q     <= '0;
      res_q     <= '0;
      key_ok_q  <= 1'b0;
      enc_dec_q <= 1'b0;
      rd_q      <= 1'b0;
    end else begin
      rd_q <= 1'b0;

      if (acc && in_kind) begin
        for (int unsigned k = 0; k < M; k++) begin
          if (kcnt_q == KW'(k)) key_q[k*N +: N] <= in_word;
        end
        kcnt_q <= (kcnt_q == KLAST) ? '0 : kcnt_q + 1'b1;
      end

      if (acc && !in_kind) begin
        if (state_q == IDLE) begin
          blk_q[2*N-1:N] <= in_word;
          enc_dec_q      <= in_dec;
        end else begin
          blk_q[N-1:0]   <= in_word;
        end
      end

      // key_ok never drops on reload: the core keeps its old schedule
      if ((state_q == KEXP) && doneKey) key_ok_q <= 1'b1;

      if ((state_q == DWAIT) && doneData) begin
        res_q <= outData;
        rd_q  <= 1'b1;
      end

`ifdef SIMON_WORD_IF_ZEROISE_EN
      if ((state_q == KREQ) && loadKey)   key_q <= '0;
      if ((state_q == DREQ) && loadData)  blk_q <= '0;
      if ((state_q == OUT1) && out_ready) res_q <= '0;
`endif
    end
  end

  assign KEY      = key_q;
  assign blockIN  = blk_q;
  assign key_ok   = key_ok_q;
  assign enc_dec  = enc_dec_q;
  assign readData = rd_q;

endmodule
